// File: rtl/access_event_logger.sv
// access_event_logger
//
// Stamps each incoming access request (user_id, resource_id) with a
// free-running cycle timestamp. Stamped events are buffered in a FIFO and
// offered on a valid/ready output stream. A downstream sink can drain them at
// its own pace. Requests that arrive while the FIFO is full, with no pop in the
// same cycle, are dropped and counted in a saturating counter.
//
// Optional feature (macro BURST_DETECT_EN): a tracker watches for runs of
// consecutive requests from the same user. Each event carries a burst bit,
// which is presented on out_burst together with the head event.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   in_valid            request present (never back-pressured)
//   in_user_id          requesting user
//   in_resource_id      requested resource
//   out_valid           head event available (FIFO not empty)
//   out_ready           sink accepts head event
//   out_timestamp       timestamp of head event
//   out_user_id         user of head event
//   out_resource_id     resource of head event
//   fifo_level          occupancy, 0..DEPTH
//   drop_count          saturating count of events lost to overflow
//   out_burst           burst flag of head event (BURST_DETECT_EN only)

module access_event_logger #(
    parameter int USER_W       = 4,
    parameter int RES_W        = 4,
    parameter int TS_W         = 16,
    parameter int DEPTH        = 8,
    parameter int DROP_W       = 8,
    parameter int BURST_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [USER_W-1:0]          in_user_id,
    input  logic [RES_W-1:0]           in_resource_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W-1:0]            out_timestamp,
    output logic [USER_W-1:0]          out_user_id,
    output logic [RES_W-1:0]           out_resource_id,
    output logic [$clog2(DEPTH):0]     fifo_level,
`ifdef BURST_DETECT_EN
    output logic [DROP_W-1:0]          drop_count,
    output logic                       out_burst
`else
    output logic [DROP_W-1:0]          drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef BURST_DETECT_EN
    localparam int FLAG_W = 1;
`else
    localparam int FLAG_W = 0;
`endif
    // Entry layout, MSB to LSB: timestamp, user, resource, optional burst flag
    localparam int ENTRY_W = TS_W + USER_W + RES_W + FLAG_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic               push, pop, drop;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pop  = (level_q != '0) && out_ready;
    assign push = in_valid && ((level_q != FULL_LVL) || pop);
    assign drop = in_valid && !push;

`ifdef BURST_DETECT_EN
    localparam int RUN_W = $clog2(BURST_THRESH + 1);
    localparam logic [RUN_W-1:0] THRESH_R = RUN_W'(BURST_THRESH);

    logic [USER_W-1:0] last_user_q, last_user_d;
    logic              last_valid_q, last_valid_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [RUN_W-1:0]  run_next;
    logic              burst_bit;

    // Every request moves the tracker, including dropped ones; idle cycles
    // leave it alone so a run survives gaps in the request stream.
    always_comb begin
        if (last_valid_q && (in_user_id == last_user_q)) begin
            run_next = (run_q == THRESH_R) ? run_q : run_q + RUN_W'(1);
        end else begin
            run_next = RUN_W'(1);
        end
        burst_bit    = (run_next >= THRESH_R);
        last_user_d  = last_user_q;
        last_valid_d = last_valid_q;
        run_d        = run_q;
        if (in_valid) begin
            last_user_d  = in_user_id;
            last_valid_d = 1'b1;
            run_d        = run_next;
        end
    end

    assign entry_in  = {ts_q, in_user_id, in_resource_id, burst_bit};
    assign out_burst = head[0];
`else
    assign entry_in = {ts_q, in_user_id, in_resource_id};
`endif

    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        drop_d   = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
    end

    // Storage is reset so the head outputs read zero straight after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? entry_in : mem_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

`ifdef BURST_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_user_q  <= '0;
            last_valid_q <= 1'b0;
            run_q        <= '0;
        end else begin
            last_user_q  <= last_user_d;
            last_valid_q <= last_valid_d;
            run_q        <= run_d;
        end
    end
`endif

    assign head            = mem_q[rd_ptr_q];
    assign out_valid       = (level_q != '0);
    assign out_resource_id = head[FLAG_W +: RES_W];
    assign out_user_id     = head[FLAG_W + RES_W +: USER_W];
    assign out_timestamp   = head[FLAG_W + RES_W + USER_W +: TS_W];
    assign fifo_level      = level_q;
    assign drop_count      = drop_q;

endmodule
